// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory port arbiter: arbitration modes,
// read-tag layout and the round-robin priority encoder.
package mem_arb_pkg;

    localparam int MAX_CH    = 8;
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // One slot of the read-return pipeline: which channel (if any) owns the data.
    typedef struct packed {
        logic              valid;
        logic [MAX_CH-1:0] ch;
    } tag_t;

    // Lowest requester inside the "at or above pointer" window, else the lowest
    // requester overall, which gives the wrap-around without a barrel shift.
    function automatic logic [MAX_CH-1:0] rr_encode(
        input logic [MAX_CH-1:0] req,
        input logic [MAX_CH-1:0] window
    );
        logic [MAX_CH-1:0] masked;
        masked = req & window;
        if (masked != '0) begin
            return masked & (~masked + MAX_CH'(1));
        end
        return req & (~req + MAX_CH'(1));
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the RAM masters and the arbiter.
interface mem_port_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_urgent;
    logic [NUM_CH-1:0]        req_wren;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_ready;
    logic [NUM_CH-1:0]        rsp_valid;
    logic [DATA_W-1:0]        rsp_data;

    modport master (
        output req_valid, req_urgent, req_wren, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_urgent, req_wren, req_addr, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational masked round-robin picker: one-hot grant to the first
// requester at or after ptr, wrapping to index 0.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant
);

    logic [MAX_CH-1:0] req_ext;
    logic [MAX_CH-1:0] window;
    logic [MAX_CH-1:0] pick;
    logic              pick_hi_unused;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_CH; gi++) begin : g_bit
            if (gi < NUM_CH) begin : g_live
                assign req_ext[gi] = req[gi];
                assign window[gi]  = (PTR_W'(gi) >= ptr);
            end else begin : g_pad
                assign req_ext[gi] = 1'b0;
                assign window[gi]  = 1'b0;
            end
        end
    endgenerate

    assign pick           = rr_encode(req_ext, window);
    assign grant          = pick[NUM_CH-1:0];
    assign pick_hi_unused = |pick;

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter sharing one synchronous single-port RAM: urgent class first,
// round-robin or fixed priority inside a class, in-order tagged read return.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int DEPTH = READ_LAT + 1;

    logic [ADDR_W-1:0] addr_arr [NUM_CH];
    logic [DATA_W-1:0] data_arr [NUM_CH];

    logic [NUM_CH-1:0] urgent_req;
    logic              any_urgent;
    logic [PTR_W-1:0]  pick_ptr;
    logic [NUM_CH-1:0] grant_urg;
    logic [NUM_CH-1:0] grant_norm;
    logic [NUM_CH-1:0] grant;
    logic              accept;

    logic [PTR_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_wren;
    logic [PTR_W-1:0]  ptr_next;
    tag_t              push_tag;

    logic [PTR_W-1:0]  rr_ptr_reg;
    logic [ADDR_W-1:0] ram_address_reg;
    logic              ram_wren_reg;
    logic [DATA_W-1:0] ram_data_reg;
    tag_t              tag_pipe_reg [DEPTH];
    logic [NUM_CH-1:0] rsp_valid_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              tag_hi_unused;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Any valid urgent request shuts the normal class out for this cycle.
    assign urgent_req = bus.req_valid & bus.req_urgent;
    assign any_urgent = |urgent_req;
    assign pick_ptr   = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr_reg;

    rr_pick #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_pick_urgent (
        .req   (urgent_req),
        .ptr   (pick_ptr),
        .grant (grant_urg)
    );

    rr_pick #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_pick_normal (
        .req   (bus.req_valid),
        .ptr   (pick_ptr),
        .grant (grant_norm)
    );

    // Grants are suppressed while reset is held so nothing is accepted then.
    assign grant         = reset_n ? (any_urgent ? grant_urg : grant_norm) : '0;
    assign accept        = |grant;
    assign bus.req_ready = grant;

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        win_wren = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                win_idx  = PTR_W'(i);
                win_addr = addr_arr[i];
                win_data = data_arr[i];
                win_wren = bus.req_wren[i];
            end
        end
    end

    assign ptr_next = (win_idx == PTR_W'(NUM_CH - 1)) ? '0 : win_idx + PTR_W'(1);

    always_comb begin
        push_tag                = '0;
        push_tag.valid          = accept & ~win_wren;
        push_tag.ch[NUM_CH-1:0] = win_wren ? '0 : grant;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_reg      <= '0;
            ram_address_reg <= '0;
            ram_wren_reg    <= 1'b0;
            ram_data_reg    <= '0;
            rsp_valid_reg   <= '0;
            rsp_data_reg    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_pipe_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                ram_address_reg <= win_addr;
                ram_data_reg    <= win_data;
                ram_wren_reg    <= win_wren;
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr_reg <= ptr_next;
                end
            end else begin
                ram_wren_reg <= 1'b0;
            end
            // Tail slot lines up with the cycle ram_q carries that read's data.
            tag_pipe_reg[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                tag_pipe_reg[i] <= tag_pipe_reg[i-1];
            end
            rsp_data_reg  <= ram_q;
            rsp_valid_reg <= tag_pipe_reg[DEPTH-1].valid ?
                             tag_pipe_reg[DEPTH-1].ch[NUM_CH-1:0] : '0;
        end
    end

    assign tag_hi_unused = |tag_pipe_reg[DEPTH-1].ch;

    assign ram_address   = ram_address_reg;
    assign ram_wren      = ram_wren_reg;
    assign ram_data      = ram_data_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin and a fixed-priority instance see the
// same directed stimulus and are compared every cycle against a behavioural model.
module tb_mem_port_arbiter;

    localparam int NUM_CH   = 3;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int READ_LAT = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    mem_port_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_rr ();
    mem_port_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_fx ();

    logic [15:0] ram_addr_rr, ram_data_rr, ram_q_rr;
    logic        ram_wren_rr;
    logic [15:0] ram_addr_fx, ram_data_fx, ram_q_fx;
    logic        ram_wren_fx;

    mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .READ_LAT(READ_LAT), .ARB_MODE(0)) dut_rr (
        .clock(clock), .reset_n(reset_n), .bus(bus_rr),
        .ram_address(ram_addr_rr), .ram_wren(ram_wren_rr),
        .ram_data(ram_data_rr), .ram_q(ram_q_rr));

    mem_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .READ_LAT(READ_LAT), .ARB_MODE(1)) dut_fx (
        .clock(clock), .reset_n(reset_n), .bus(bus_fx),
        .ram_address(ram_addr_fx), .ram_wren(ram_wren_fx),
        .ram_data(ram_data_fx), .ram_q(ram_q_fx));

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A00;
    endfunction

    // RAM models: one-cycle registered read, unwritten words hold init_val.
    logic [15:0] mem_rr [65536];
    bit          wr_rr  [65536];
    logic [15:0] mem_fx [65536];
    bit          wr_fx  [65536];

    always @(posedge clock) begin
        if (ram_wren_rr) begin
            mem_rr[ram_addr_rr] <= ram_data_rr;
            wr_rr[ram_addr_rr]  <= 1'b1;
        end
        ram_q_rr <= wr_rr[ram_addr_rr] ? mem_rr[ram_addr_rr] : init_val(ram_addr_rr);
    end

    always @(posedge clock) begin
        if (ram_wren_fx) begin
            mem_fx[ram_addr_fx] <= ram_data_fx;
            wr_fx[ram_addr_fx]  <= 1'b1;
        end
        ram_q_fx <= wr_fx[ram_addr_fx] ? mem_fx[ram_addr_fx] : init_val(ram_addr_fx);
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          inst;
        int          due;
        int          ch;
        logic [15:0] data;
    } rsp_t;

    rsp_t        rq [$];
    int          m_ptr  [2];
    logic [15:0] e_addr [2];
    logic [15:0] e_data [2];
    logic        e_wren [2];
    logic [15:0] sh0 [int];
    logic [15:0] sh1 [int];

    function automatic logic [15:0] model_rd(input int k, input logic [15:0] a);
        if (k == 0) return sh0.exists(int'(a)) ? sh0[int'(a)] : init_val(a);
        return sh1.exists(int'(a)) ? sh1[int'(a)] : init_val(a);
    endfunction

    // Competing set is the urgent valids if there are any, else all valids;
    // scan from ptr upwards modulo NUM_CH.
    function automatic int model_pick(input logic [2:0] v, input logic [2:0] u, input int ptr);
        logic [2:0] comp;
        comp = ((v & u) != 3'b000) ? (v & u) : v;
        for (int s = 0; s < NUM_CH; s++) begin
            if (comp[(ptr + s) % NUM_CH]) return (ptr + s) % NUM_CH;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [2:0] oh);
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_inst(
        input int k, input string nm,
        input logic [2:0] v, input logic [2:0] u, input logic [2:0] w,
        input logic [47:0] a, input logic [47:0] d,
        input logic [2:0] rdy, input logic [2:0] rv, input logic [15:0] rd,
        input logic [15:0] ra, input logic rw, input logic [15:0] rdat
    );
        int          win;
        logic [2:0]  exp_rv;
        logic [15:0] exp_rd;
        rsp_t        keep [$];
        logic [15:0] wa;
        if (!reset_n) begin
            chk({nm, " rst ready"},     32'(rdy),  32'(0));
            chk({nm, " rst rsp_valid"}, 32'(rv),   32'(0));
            chk({nm, " rst rsp_data"},  32'(rd),   32'(0));
            chk({nm, " rst ram_addr"},  32'(ra),   32'(0));
            chk({nm, " rst ram_wren"},  32'(rw),   32'(0));
            chk({nm, " rst ram_data"},  32'(rdat), 32'(0));
            m_ptr[k]  = 0;
            e_addr[k] = '0;
            e_data[k] = '0;
            e_wren[k] = 1'b0;
            foreach (rq[i]) if (rq[i].inst != k) keep.push_back(rq[i]);
            rq = keep;
            return;
        end
        win = model_pick(v, u, (k == 1) ? 0 : m_ptr[k]);
        chk({nm, " ready"},    32'(rdy),  (win >= 0) ? (32'd1 << win) : 32'd0);
        chk({nm, " ram_addr"}, 32'(ra),   32'(e_addr[k]));
        chk({nm, " ram_wren"}, 32'(rw),   32'(e_wren[k]));
        chk({nm, " ram_data"}, 32'(rdat), 32'(e_data[k]));
        exp_rv = '0;
        exp_rd = '0;
        foreach (rq[i]) begin
            if (rq[i].inst == k && rq[i].due == cyc) begin
                exp_rv = 3'(1 << rq[i].ch);
                exp_rd = rq[i].data;
            end
            if (rq[i].inst != k || rq[i].due > cyc) keep.push_back(rq[i]);
        end
        rq = keep;
        chk({nm, " rsp_valid"}, 32'(rv), 32'(exp_rv));
        if (exp_rv != 3'b000) chk({nm, " rsp_data"}, 32'(rd), 32'(exp_rd));
        if (win >= 0) begin
            wa        = a[win*16 +: 16];
            e_addr[k] = wa;
            e_data[k] = d[win*16 +: 16];
            e_wren[k] = w[win];
            if (w[win]) begin
                if (k == 0) sh0[int'(wa)] = d[win*16 +: 16];
                else        sh1[int'(wa)] = d[win*16 +: 16];
            end else begin
                rq.push_back('{inst: k, due: cyc + READ_LAT + 2, ch: win, data: model_rd(k, wa)});
            end
            if (k == 0) m_ptr[k] = (win + 1) % NUM_CH;
            $display("[cyc %0d] %s accept ch%0d %s addr=%h data=%h", cyc, nm, win,
                     w[win] ? "write" : "read", wa, d[win*16 +: 16]);
        end else begin
            e_wren[k] = 1'b0;
        end
    endtask

    // Per-cycle observation logs, indexed by cycle number, for literal checks.
    int          gr_rr [$];
    int          gr_fx [$];
    logic [15:0] ra_rr [$];
    logic [18:0] rsp_rr [$];

    always @(negedge clock) begin
        check_inst(0, "rr", bus_rr.req_valid, bus_rr.req_urgent, bus_rr.req_wren,
                   bus_rr.req_addr, bus_rr.req_data, bus_rr.req_ready, bus_rr.rsp_valid,
                   bus_rr.rsp_data, ram_addr_rr, ram_wren_rr, ram_data_rr);
        check_inst(1, "fx", bus_fx.req_valid, bus_fx.req_urgent, bus_fx.req_wren,
                   bus_fx.req_addr, bus_fx.req_data, bus_fx.req_ready, bus_fx.rsp_valid,
                   bus_fx.rsp_data, ram_addr_fx, ram_wren_fx, ram_data_fx);
        gr_rr.push_back(oh2i(bus_rr.req_ready));
        gr_fx.push_back(oh2i(bus_fx.req_ready));
        ra_rr.push_back(ram_addr_rr);
        rsp_rr.push_back({bus_rr.rsp_valid, bus_rr.rsp_data});
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [2:0] v, input logic [2:0] u, input logic [2:0] w,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                         input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        bus_rr.req_valid = v;  bus_fx.req_valid = v;
        bus_rr.req_urgent = u; bus_fx.req_urgent = u;
        bus_rr.req_wren = w;   bus_fx.req_wren = w;
        bus_rr.req_addr = {a2, a1, a0}; bus_fx.req_addr = {a2, a1, a0};
        bus_rr.req_data = {d2, d1, d0}; bus_fx.req_data = {d2, d1, d0};
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int base, b2, bw, br, bx, brel;
        int exp_seq [6];
        exp_seq = '{0, 1, 2, 0, 1, 2};
        drive(3'b000, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        step(3);
        reset_n = 1'b1;
        step(10);

        // All three channels reading continuously.
        drive(3'b111, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        base = cyc;
        step(6);
        drive(3'b000, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) chk("rr grant order", 32'(gr_rr[base+i]), 32'(exp_seq[i]));
        chk("rr ram_addr 1st", 32'(ra_rr[base+1]), 32'h0010);
        chk("rr ram_addr 2nd", 32'(ra_rr[base+2]), 32'h0020);
        chk("rr ram_addr 3rd", 32'(ra_rr[base+3]), 32'h0030);
        chk("rr rsp 1st", 32'(rsp_rr[base+3]), 32'({3'b001, 16'h5A10}));
        chk("rr rsp 2nd", 32'(rsp_rr[base+4]), 32'({3'b010, 16'h5A20}));
        chk("fx grant ch0", 32'(gr_fx[base+1]), 32'd0);
        step(4);

        // ch0 normal and ch2 urgent together, then ch2 drops.
        drive(3'b101, 3'b100, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        base = cyc;
        step(3);
        drive(3'b001, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        b2 = cyc;
        step(1);
        drive(3'b000, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) chk("urgent wins", 32'(gr_rr[base+i]), 32'd2);
        chk("normal after urgent", 32'(gr_rr[b2]), 32'd0);
        chk("fx normal after urgent", 32'(gr_fx[b2]), 32'd0);
        step(4);

        // Write 0xBEEF to 0x0040 on ch1, then read it back on ch0.
        drive(3'b010, 3'b000, 3'b010, 16'h0000, 16'h0040, 16'h0000, 16'h0, 16'hBEEF, 16'h0);
        bw = cyc;
        step(1);
        drive(3'b001, 3'b000, 3'b000, 16'h0040, 16'h0040, 16'h0000, 16'h0, 16'hBEEF, 16'h0);
        br = cyc;
        step(1);
        drive(3'b000, 3'b000, 3'b000, 16'h0040, 16'h0040, 16'h0000, 16'h0, 16'h0, 16'h0);
        step(5);
        chk("write grant", 32'(gr_rr[bw]), 32'd1);
        chk("read grant", 32'(gr_rr[br]), 32'd0);
        chk("no write rsp", 32'(rsp_rr[bw+3][18:16]), 32'd0);
        chk("read after write", 32'(rsp_rr[br+3]), 32'({3'b001, 16'hBEEF}));

        // ch1 and ch2 together: fixed priority always picks ch1.
        drive(3'b110, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        base = cyc;
        step(5);
        drive(3'b000, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) chk("fx fixed ch1", 32'(gr_fx[base+i]), 32'd1);
        step(4);

        // Read accepted, then reset pulsed one cycle later with all channels valid.
        drive(3'b001, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        bx = cyc;
        step(1);
        drive(3'b000, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        step(1);
        reset_n = 1'b0;
        drive(3'b111, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        step(1);
        reset_n = 1'b1;
        brel = cyc;
        step(3);
        drive(3'b000, 3'b000, 3'b000, 16'h0010, 16'h0020, 16'h0030, 16'h0, 16'h0, 16'h0);
        step(5);
        chk("pre-reset grant", 32'(gr_rr[bx]), 32'd0);
        chk("no grant in reset", 32'(gr_rr[bx+2]), 32'hFFFF_FFFF);
        chk("ram_addr in reset", 32'(ra_rr[bx+2]), 32'd0);
        chk("no rsp after reset", 32'(rsp_rr[brel][18:16]), 32'd0);
        chk("no rsp after reset +1", 32'(rsp_rr[brel+1][18:16]), 32'd0);
        chk("first grant after reset", 32'(gr_rr[brel]), 32'd0);
        chk("second grant after reset", 32'(gr_rr[brel+1]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
